// File: rtl/spart_mmio_pkg.sv
// Shared definitions for the SPART memory-mapped bridge: register offsets,
// STATUS bit positions and the bus-handshake state encoding.
package spart_mmio_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_DIV    = 2'd3;

  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_SPACE = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_TX_EMPTY = 3;
  localparam int ST_FLAG_LSB = 4;   // rx_ovf, tx_ovf, rx_udf, frame_err
  localparam int ST_RX_CNT   = 8;
  localparam int ST_TX_CNT   = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/spart_sync_fifo.sv
// Single-clock FIFO with occupancy count; push and pop in the same cycle
// leave the count unchanged. Push when full and pop when empty are ignored.
module spart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spart_mmio_bridge.sv
// Cache I/O port to SPART bridge: four-register map with TX/RX FIFOs,
// baud divisor, sticky error flags and a registered interrupt.
module spart_mmio_bridge
  import spart_mmio_pkg::*;
#(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 28,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 28'h800_0000,
  parameter int                 TX_DEPTH  = 16,
  parameter int                 RX_DEPTH  = 16,
  parameter int                 DIV_W     = 16,
  parameter logic [DIV_W-1:0]   DIV_RESET = DIV_W'(325)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               io_valid_data,
  input  logic               io_rw_data,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  io_wr_data,
  output logic [DATA_W-1:0]  io_rd_data,
  output logic               io_ready_data,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic               rx_frame_err,
  output logic [DIV_W-1:0]   baud_div,
  output logic               irq
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int WL    = (DIV_W > 8) ? DIV_W : 8;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic              unused_wdata;

  logic [ADDR_W-1:0] offset;
  logic [1:0]        reg_sel;
  logic              hit, access, wr_req, rd_req;
  logic              data_wr, data_rd, status_rd, ctrl_wr, div_wr;

  logic              tx_full, tx_empty, tx_push, tx_pop;
  logic              rx_full, rx_empty, rx_push, rx_pop;
  logic [7:0]        rx_head;
  logic [TX_CW-1:0]  tx_count;
  logic [RX_CW-1:0]  rx_count;

  logic [1:0]        ctrl;
  logic [3:0]        err_flags;
  logic [3:0]        err_set;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] rd_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (io_valid_data) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign io_ready_data = (state == S_RESP);

  // request capture: address, direction and data are held through ACCESS
  always_ff @(posedge clk) begin
    if (state == S_IDLE && io_valid_data) begin
      addr_q  <= mem_addr;
      rw_q    <= io_rw_data;
      wdata_q <= io_wr_data;
    end
  end

  assign unused_wdata = ^wdata_q[DATA_W-1:WL];

  // Unsigned subtraction sends addresses below the base far out of range.
  assign offset    = addr_q - BASE_ADDR;
  assign hit       = (offset[ADDR_W-1:2] == '0);
  assign reg_sel   = offset[1:0];
  assign access    = (state == S_ACCESS);
  assign wr_req    = access & hit & rw_q;
  assign rd_req    = access & hit & ~rw_q;
  assign data_wr   = wr_req & (reg_sel == REG_DATA);
  assign data_rd   = rd_req & (reg_sel == REG_DATA);
  assign status_rd = rd_req & (reg_sel == REG_STATUS);
  assign ctrl_wr   = wr_req & (reg_sel == REG_CTRL);
  assign div_wr    = wr_req & (reg_sel == REG_DIV);

  assign tx_valid = ~tx_empty;
  assign tx_push  = data_wr & ~tx_full;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_push  = rx_valid & ~rx_full;
  assign rx_pop   = data_rd & ~rx_empty;

  spart_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (wdata_q[7:0]),
    .pop       (tx_pop),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  spart_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  // flag order matches STATUS bits 4..7: rx_ovf, tx_ovf, rx_udf, frame_err
  assign err_set = {rx_valid & rx_frame_err,
                    data_rd & rx_empty,
                    data_wr & tx_full,
                    rx_valid & rx_full};

  always_comb begin
    status                   = '0;
    status[ST_RX_AVAIL]      = ~rx_empty;
    status[ST_TX_SPACE]      = ~tx_full;
    status[ST_RX_FULL]       = rx_full;
    status[ST_TX_EMPTY]      = tx_empty;
    status[ST_FLAG_LSB +: 4] = err_flags;
    status[ST_RX_CNT +: 8]   = 8'(rx_count);
    status[ST_TX_CNT +: 8]   = 8'(tx_count);
  end

  always_comb begin
    rd_next = '0;
    if (rd_req) begin
      case (reg_sel)
        REG_DATA:   if (!rx_empty) rd_next[7:0] = rx_head;
        REG_STATUS: rd_next = status;
        REG_CTRL:   rd_next[1:0] = ctrl;
        REG_DIV:    rd_next[DIV_W-1:0] = baud_div;
        default:    rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl       <= '0;
      baud_div   <= DIV_RESET;
      err_flags  <= '0;
      irq        <= 1'b0;
      io_rd_data <= '0;
    end else begin
      if (ctrl_wr) ctrl     <= wdata_q[1:0];
      if (div_wr)  baud_div <= wdata_q[DIV_W-1:0];
      // STATUS read clears after capture; a same-cycle set event wins
      err_flags <= (err_flags & ~{4{status_rd}}) | err_set;
      irq       <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty);
      if (access) io_rd_data <= rd_next;
    end
  end

endmodule

// File: tb/tb_spart_mmio_bridge.sv
// Directed bench for spart_mmio_bridge: queue-based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_spart_mmio_bridge;

  localparam logic [27:0] BASE = 28'h800_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        io_valid_data = 1'b0;
  logic        io_rw_data = 1'b0;
  logic [27:0] mem_addr = '0;
  logic [31:0] io_wr_data = '0;
  logic [31:0] io_rd_data;
  logic        io_ready_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_frame_err = 1'b0;
  logic [15:0] baud_div;
  logic        irq;

  int errors = 0;
  int checks = 0;
  bit started = 0;

  always #5 clk = ~clk;

  spart_mmio_bridge dut (
    .clk           (clk),
    .rst           (rst),
    .io_valid_data (io_valid_data),
    .io_rw_data    (io_rw_data),
    .mem_addr      (mem_addr),
    .io_wr_data    (io_wr_data),
    .io_rd_data    (io_rd_data),
    .io_ready_data (io_ready_data),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_frame_err  (rx_frame_err),
    .baud_div      (baud_div),
    .irq           (irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFOs as queues, register file as plain variables.
  byte unsigned m_tx[$];
  byte unsigned m_rx[$];
  logic [7:0]  m_flags;
  logic [1:0]  m_ctrl;
  logic [15:0] m_div;
  logic        m_irq, m_ready, m_rw;
  logic [31:0] m_rd, m_wd;
  logic [27:0] m_addr;
  int          m_phase;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tx.delete();
      m_rx.delete();
      m_flags = '0;
      m_ctrl  = '0;
      m_div   = 16'd325;
      m_irq   = 1'b0;
      m_ready = 1'b0;
      m_rd    = '0;
      m_phase = 0;
    end else begin
      int ts, rs;
      logic [31:0] st;
      logic [27:0] off;
      logic [7:0]  set;
      bit tx_push, rx_pop, clr, next_irq;
      ts = m_tx.size();
      rs = m_rx.size();
      st = {8'h00, 8'(ts), 8'(rs), m_flags[7:4], (ts == 0), (rs == 16), (ts < 16), (rs > 0)};
      next_irq = (m_ctrl[0] && rs > 0) || (m_ctrl[1] && ts == 0);
      tx_push = 0; rx_pop = 0; clr = 0; set = '0;
      m_ready = 1'b0;
      if (m_phase == 1) begin
        off  = m_addr - BASE;
        m_rd = '0;
        if (off < 28'd4) begin
          case (off[1:0])
            2'd0: begin
              if (m_rw) begin
                if (ts == 16) set[5] = 1'b1; else tx_push = 1;
              end else begin
                if (rs > 0) begin m_rd = 32'(m_rx[0]); rx_pop = 1; end
                else set[6] = 1'b1;
              end
            end
            2'd1: if (!m_rw) begin m_rd = st; clr = 1; end
            2'd2: if (m_rw) m_ctrl = m_wd[1:0]; else m_rd = 32'(m_ctrl);
            default: if (m_rw) m_div = m_wd[15:0]; else m_rd = 32'(m_div);
          endcase
        end
        m_phase = 2;
        m_ready = 1'b1;
      end else if (m_phase == 2) begin
        m_phase = 0;
      end else if (io_valid_data) begin
        m_addr  = mem_addr;
        m_rw    = io_rw_data;
        m_wd    = io_wr_data;
        m_phase = 1;
      end
      if (ts > 0 && tx_ready) void'(m_tx.pop_front());
      if (tx_push) m_tx.push_back(m_wd[7:0]);
      if (rx_pop) void'(m_rx.pop_front());
      if (rx_valid) begin
        if (rs == 16) set[4] = 1'b1; else m_rx.push_back(rx_data);
        if (rx_frame_err) set[7] = 1'b1;
      end
      if (clr) m_flags = '0;
      m_flags = m_flags | set;
      m_irq = next_irq;
    end
  end

  always @(negedge clk) begin
    if (rst && started) begin
      chk("m_ready", io_ready_data, m_ready);
      if (m_ready && !m_rw) chk("m_rd_data", io_rd_data, m_rd);
      chk("m_tx_valid", tx_valid, m_tx.size() > 0);
      if (m_tx.size() > 0) chk("m_tx_data", tx_data, m_tx[0]);
      chk("m_baud_div", baud_div, m_div);
      chk("m_irq", irq, m_irq);
    end
  end

  task automatic bus(input bit rw, input logic [27:0] a, input logic [31:0] d,
                     output logic [31:0] rd,
                     input bit inj = 0, input logic [7:0] ib = 8'h00, input bit ife = 0);
    int n;
    @(negedge clk);
    io_valid_data = 1'b1; io_rw_data = rw; mem_addr = a; io_wr_data = d;
    n = 0;
    rd = '0;
    while (n < 8) begin
      @(negedge clk);
      n++;
      if (n == 1 && inj) begin
        rx_valid = 1'b1; rx_data = ib; rx_frame_err = ife;
      end else if (n == 2) begin
        rx_valid = 1'b0; rx_frame_err = 1'b0;
      end
      if (io_ready_data) break;
    end
    chk("latency", n, 2);
    rd = io_rd_data;
    io_valid_data = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b, input bit fe);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b; rx_frame_err = fe;
    @(negedge clk);
    rx_valid = 1'b0; rx_frame_err = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    repeat (2) @(negedge clk);
    chk("rst_ready", io_ready_data, 0);
    chk("rst_rd", io_rd_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_irq", irq, 0);
    chk("rst_div", baud_div, 325);
    #1 rst = 1'b1;
    started = 1;

    // single TX write then drain
    bus(1, BASE, 32'h41, r);
    chk("tx_valid_wr", tx_valid, 1);
    chk("tx_data_wr", tx_data, 32'h41);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk("tx_drained", tx_valid, 0);

    // RX bytes read back in order
    rx_byte(8'h5A, 0);
    rx_byte(8'h3C, 0);
    bus(0, BASE, 0, r);
    chk("rx_pop1", r, 32'h5A);
    bus(0, BASE, 0, r);
    chk("rx_pop2", r, 32'h3C);
    bus(0, BASE + 28'd1, 0, r);
    chk("st_rx_avail", r[0], 0);
    chk("st_rx_cnt0", r[15:8], 0);
    chk("st_tx_empty", r[3], 1);
    chk("st_upper", r[31:24], 0);

    // TX overflow with 17 writes
    for (int i = 0; i < 17; i++) bus(1, BASE, 32'h80 + i, r);
    bus(0, BASE + 28'd1, 0, r);
    chk("st_tx_cnt16", r[23:16], 16);
    chk("st_tx_ovf", r[5], 1);
    chk("st_tx_space0", r[1], 0);
    chk("st_tx_empty0", r[3], 0);
    bus(0, BASE + 28'd1, 0, r);
    chk("st_tx_ovf_clr", r[5], 0);
    chk("st_tx_cnt16b", r[23:16], 16);
    tx_ready = 1'b1;
    repeat (17) @(negedge clk);
    tx_ready = 1'b0;
    chk("tx_drain_all", tx_valid, 0);

    // RX underflow
    bus(0, BASE, 0, r);
    chk("rx_udf_data", r, 0);
    bus(0, BASE + 28'd1, 0, r);
    chk("st_rx_udf", r[6], 1);

    // framing error stores the byte
    rx_byte(8'hE1, 1);
    bus(0, BASE + 28'd1, 0, r);
    chk("st_frame_err", r[7], 1);
    chk("st_rx_cnt1", r[15:8], 1);
    chk("st_udf_clr", r[6], 0);
    bus(0, BASE, 0, r);
    chk("rx_frame_byte", r, 32'hE1);

    // set event in the clearing cycle wins
    bus(0, BASE + 28'd1, 0, r, 1, 8'h77, 1);
    chk("st_clr_cycle_pre", r[7], 0);
    bus(0, BASE + 28'd1, 0, r);
    chk("st_set_wins", r[7], 1);
    chk("st_rx_cnt_inj", r[15:8], 1);
    bus(0, BASE, 0, r);
    chk("rx_inj_byte", r, 32'h77);

    // RX overflow
    for (int i = 0; i < 17; i++) rx_byte(8'h10 + 8'(i), 0);
    bus(0, BASE + 28'd1, 0, r);
    chk("st_rx_ovf", r[4], 1);
    chk("st_rx_full", r[2], 1);
    chk("st_rx_cnt16", r[15:8], 16);
    for (int i = 0; i < 16; i++) begin
      bus(0, BASE, 0, r);
      chk("rx_ovf_order", r, 32'h10 + i);
    end

    // DIV and CTRL registers, interrupt
    bus(1, BASE + 28'd3, 32'hFFFF_00A2, r);
    chk("baud_div_a2", baud_div, 16'h00A2);
    bus(0, BASE + 28'd3, 0, r);
    chk("div_readback", r, 32'hA2);
    bus(1, BASE + 28'd2, 32'hFFFF_FFFF, r);
    bus(0, BASE + 28'd2, 0, r);
    chk("ctrl_readback", r, 3);
    chk("irq_tx_empty", irq, 1);
    bus(1, BASE + 28'd2, 32'h1, r);
    repeat (2) @(negedge clk);
    chk("irq_rx_only_idle", irq, 0);
    rx_byte(8'h55, 0);
    @(negedge clk);
    chk("irq_rx_byte", irq, 1);
    bus(0, BASE, 0, r);
    chk("irq_pop_byte", r, 32'h55);
    chk("irq_still_set", irq, 1);
    @(negedge clk);
    chk("irq_cleared", irq, 0);

    // reset in the middle of an access
    rx_byte(8'h66, 0);
    @(negedge clk);
    io_valid_data = 1'b1; io_rw_data = 1'b1; mem_addr = BASE; io_wr_data = 32'h99;
    @(negedge clk);
    #1 rst = 1'b0;
    io_valid_data = 1'b0;
    @(negedge clk);
    chk("abort_ready", io_ready_data, 0);
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_div", baud_div, 325);
    chk("abort_irq", irq, 0);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_no_pulse", io_ready_data, 0);
    bus(0, BASE + 28'd1, 0, r);
    chk("abort_rx_cnt", r[15:8], 0);
    chk("abort_tx_cnt", r[23:16], 0);
    chk("abort_flags", r[7:4], 0);
    chk("abort_tx_empty", r[3], 1);
    bus(0, BASE + 28'd2, 0, r);
    chk("abort_ctrl", r, 0);

    // unmapped addresses, including aliases of DIV in the low bits
    bus(0, BASE + 28'd7, 0, r);
    chk("unmapped_rd", r, 0);
    bus(1, BASE + 28'd7, 32'h12, r);
    bus(0, BASE - 28'd1, 0, r);
    chk("below_base_rd", r, 0);
    bus(0, BASE + 28'd3, 0, r);
    chk("div_untouched", r, 325);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spart_mmio_bridge.md
Name: spart_mmio_bridge

Overview:
Parametrised memory-mapped front end between the processor cache I/O port and a byte-level SPART core. It adds TX/RX FIFOs, a four-register map at a configurable base address, a programmable baud divisor, sticky error flags and an interrupt line. It sits where the cache interface meets the SPART and has a fixed-latency valid/ready handshake.

Parameters:
DATA_W, 32, width of io_wr_data/io_rd_data (min 24, to hold the STATUS fields)
ADDR_W, 28, width of mem_addr (word address)
BASE_ADDR, 28'h800_0000, word address of register 0
TX_DEPTH, 16, TX FIFO entries (power of 2, 2..128)
RX_DEPTH, 16, RX FIFO entries (power of 2, 2..128)
DIV_W, 16, baud divisor width
DIV_RESET, 325, reset divisor (100 MHz, 19200 baud, x16)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
io_valid_data  input  1  request valid, held until io_ready_data
io_rw_data  input  1  1 = write, 0 = read
mem_addr  input  ADDR_W  word address
io_wr_data  input  DATA_W  write data
io_rd_data  output  DATA_W  read data, valid while io_ready_data=1
io_ready_data  output  1  one-cycle completion pulse
tx_data  output  8  byte to SPART (TX FIFO head)
tx_valid  output  1  TX FIFO non-empty
tx_ready  input  1  SPART accepts byte
rx_data  input  8  received byte
rx_valid  input  1  one-cycle strobe, rx_data valid
rx_frame_err  input  1  framing error qualifier with rx_valid
baud_div  output  DIV_W  divisor to SPART baud generator
irq  output  1  registered interrupt

Behaviour:
- Reset (rst=0, async): FSM=IDLE; FIFOs empty; sticky flags 0; CTRL=0; baud_div=DIV_RESET; io_ready_data=0; io_rd_data=0; tx_valid=0; irq=0.
- Register map, offset = mem_addr-BASE_ADDR: 0 DATA (read pops RX, write pushes io_wr_data[7:0] to TX); 1 STATUS (read-only); 2 CTRL (RW, bit0 rx_irq_en, bit1 tx_irq_en, rest read 0); 3 DIV (RW, [DIV_W-1:0]). Other addresses: read 0, write ignored, still completes.
- STATUS: b0 rx_avail, b1 tx_space, b2 rx_full, b3 tx_empty, b4 rx_ovf, b5 tx_ovf, b6 rx_udf, b7 frame_err, [15:8] rx count, [23:16] tx count, upper bits 0.
- FSM IDLE -> ACCESS -> RESP -> IDLE. IDLE: io_valid_data=1 latches addr/rw/data. ACCESS: decode, FIFO push/pop, register update, io_rd_data registered. RESP: io_ready_data=1 for exactly one cycle. Latency: ready two cycles after valid is first sampled. The requester drops valid the cycle after ready; valid high in IDLE is a new request.
- Write DATA with TX full: byte dropped, tx_ovf set. Read DATA with RX empty: returns 0, no pop, rx_udf set.
- rx_valid with RX full: byte dropped, rx_ovf set. rx_valid with rx_frame_err=1: byte stored, frame_err set.
- A STATUS read clears b4-b7 in ACCESS, after io_rd_data captures them. A set event in the same cycle wins and the flag stays 1.
- TX drain: tx_data=head, pop when tx_valid & tx_ready. A simultaneous bus push and drain pop is legal, count unchanged. Same rule for the RX side.
- irq next cycle = (rx_irq_en & rx_avail) | (tx_irq_en & tx_empty).
- Pointers wrap modulo depth. Counts are clog2(depth)+1 bits, zero-extended into 8-bit fields.
- Reset mid-transaction: abort, no io_ready_data pulse, all state to reset values.

Decomposition:
- Package spart_mmio_pkg: register offsets (REG_DATA=0, REG_STATUS=1, REG_CTRL=2, REG_DIV=3), STATUS bit indices, FSM state encoding.
- Sub-module spart_sync_fifo (WIDTH, DEPTH): push/pop, full/empty/count, same-cycle push+pop; instantiated for TX and RX.

Test Plan:
- Write 0x41 to 0x800_0000 -> io_ready_data 2 cycles after valid; tx_valid=1, tx_data=0x41; tx_ready=1 one cycle -> tx_valid=0.
- Inject rx_valid 0x5A, 0x3C, then read 0x800_0000 twice -> io_rd_data 0x5A then 0x3C; STATUS read -> rx_avail=0, b[15:8]=0.
- 17 writes with tx_ready=0 (TX_DEPTH=16) -> STATUS [23:16]=16, b5=1; second STATUS read -> b5=0.
- Read DATA when RX empty -> 0, b6=1. rx_valid with rx_frame_err=1 -> b7=1. rx_valid in the STATUS-clear cycle -> corresponding flag remains 1.
- Write DIV 0x00A2 -> baud_div=0x00A2, readback 0xA2. CTRL=1 plus one RX byte -> irq=1; pop that byte -> irq=0 next cycle.
- Assert rst=0 during ACCESS -> no ready pulse, FIFOs empty, baud_div=325. Access 0x800_0007 -> reads 0, completes in 2 cycles.
